// File: rtl/euler_runner.sv
// Run controller for an attached solver: pulses the solver reset, enables it,
// waits for a rising completion flag or a timeout, and records the verdict.
module euler_runner #(
  parameter int          WIDTH          = 32,
  parameter int          RESET_CYCLES   = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] max_value,
  input  logic [WIDTH-1:0] expected,
  output logic             solver_reset,
  output logic             solver_enable,
  output logic [WIDTH-1:0] solver_max_value,
  input  logic             solver_results_valid,
  input  logic [WIDTH-1:0] solver_results,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timed_out,
  output logic [WIDTH-1:0] result,
  output logic [31:0]      cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0]  RST_LOAD  = 8'(RESET_CYCLES - 1);
  localparam logic [31:0] LAST_RUN  = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

  state_t           state_q, state_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [31:0]      cycles_q, cycles_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timed_out_q, timed_out_d;
  logic             valid_q, valid_d;
  logic             valid_rise;

  assign valid_rise = solver_results_valid && !valid_q;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    max_d       = max_q;
    exp_d       = exp_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timed_out_d = timed_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RST;
          rst_cnt_d   = RST_LOAD;
          max_d       = max_value;
          exp_d       = expected;
          result_d    = '0;
          cycles_d    = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      RST: begin
        if (rst_cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      RUN: begin
        cycles_d = (cycles_q == CYCLE_MAX) ? cycles_q : cycles_q + 32'd1;
        // A completion edge wins over a timeout landing in the same cycle.
        if (valid_rise) begin
          state_d  = DONE;
          result_d = solver_results;
          pass_d   = (solver_results == exp_q);
          fail_d   = (solver_results != exp_q);
        end else if (cycles_q == LAST_RUN) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
          fail_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Keyed on the next state so valid_q reads 0 throughout RST yet picks up a
  // level still high at the RST->RUN transition, so a stuck flag is no edge.
  assign valid_d = (state_d == RST) ? 1'b0 : solver_results_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      max_q       <= '0;
      exp_q       <= '0;
      result_q    <= '0;
      cycles_q    <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timed_out_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      max_q       <= max_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timed_out_q <= timed_out_d;
      valid_q     <= valid_d;
    end
  end

  // Reset gates the state decodes so the abort is visible in the reset cycle.
  assign solver_reset     = reset || (state_q == RST);
  assign solver_enable    = !reset && (state_q == RUN);
  assign busy             = !reset && ((state_q == RST) || (state_q == RUN));
  assign done             = !reset && (state_q == DONE);
  assign solver_max_value = max_q;
  assign pass             = pass_q;
  assign fail             = fail_q;
  assign timed_out        = timed_out_q;
  assign result           = result_q;
  assign cycles           = cycles_q;

endmodule

// File: tb/tb_euler_runner.sv
// Directed bench: one runner driving a behavioural even-Fibonacci solver and a
// second runner (TIMEOUT_CYCLES=16) driving a bench-controlled stub solver.
module tb_euler_runner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_e = 1'b0, start_t = 1'b0;
  logic [31:0] max_e = '0, exp_e = '0, max_t = '0, exp_t = '0;
  logic        stub_valid = 1'b0;
  logic [31:0] stub_result = 32'h0000_ABCD;

  logic        sr_e, en_e, busy_e, done_e, pass_e, fail_e, to_e;
  logic [31:0] smax_e, result_e, cycles_e;
  logic        sr_t, en_t, busy_t, done_t, pass_t, fail_t, to_t;
  logic [31:0] smax_t, result_t, cycles_t;

  logic        ev;
  logic [31:0] prev, cur, sum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  euler_runner #(.WIDTH(32), .RESET_CYCLES(2), .TIMEOUT_CYCLES(32'd50000)) dut_e (
    .clk(clk), .reset(reset), .start(start_e), .max_value(max_e), .expected(exp_e),
    .solver_reset(sr_e), .solver_enable(en_e), .solver_max_value(smax_e),
    .solver_results_valid(ev), .solver_results(sum),
    .busy(busy_e), .done(done_e), .pass(pass_e), .fail(fail_e), .timed_out(to_e),
    .result(result_e), .cycles(cycles_e)
  );

  euler_runner #(.WIDTH(32), .RESET_CYCLES(2), .TIMEOUT_CYCLES(32'd16)) dut_t (
    .clk(clk), .reset(reset), .start(start_t), .max_value(max_t), .expected(exp_t),
    .solver_reset(sr_t), .solver_enable(en_t), .solver_max_value(smax_t),
    .solver_results_valid(stub_valid), .solver_results(stub_result),
    .busy(busy_t), .done(done_t), .pass(pass_t), .fail(fail_t), .timed_out(to_t),
    .result(result_t), .cycles(cycles_t)
  );

  // Sum of even Fibonacci terms not exceeding the bound, one even term per cycle.
  always_ff @(posedge clk) begin
    if (sr_e) begin
      prev <= 32'd0;
      cur  <= 32'd2;
      sum  <= 32'd0;
      ev   <= 1'b0;
    end else if (en_e && !ev) begin
      if (cur > smax_e) begin
        ev <= 1'b1;
      end else begin
        sum  <= sum + cur;
        prev <= cur;
        cur  <= 32'd4 * cur + prev;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wait_done(input bit sel_t, input int limit, input string tag);
    int n = 0;
    while (!(sel_t ? done_t : done_e) && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(sel_t ? done_t : done_e), 32'd1);
  endtask

  task automatic wait_enable_t(input string tag);
    int n = 0;
    while (!en_t && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(en_t), 32'd1);
  endtask

  task automatic pulse_start_t(input logic [31:0] mx, input logic [31:0] ex);
    max_t = mx; exp_t = ex; start_t = 1'b1;
    tick();
    start_t = 1'b0;
  endtask

  initial begin
    int rn, en, n;

    // Reset state
    #1;
    check("rst_solver_reset_e", 32'(sr_e), 32'd1);
    tick(); tick();
    check("rst_busy_done_e", {30'd0, busy_e, done_e}, 32'd0);
    check("rst_verdict_t", {29'd0, pass_t, fail_t, to_t}, 32'd0);
    check("rst_cycles_t", cycles_t, 32'd0);
    check("rst_enable_t", 32'(en_t), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_solver_reset_t", 32'(sr_t), 32'd0);

    // Timeout with valid tied low
    pulse_start_t(32'd7, 32'd9);
    check("to_busy", 32'(busy_t), 32'd1);
    check("to_smax", smax_t, 32'd7);
    rn = 0; en = 0; n = 0;
    while (!done_t && n < 100) begin
      if (sr_t) rn++;
      if (en_t) en++;
      tick();
      n++;
    end
    check("to_done", 32'(done_t), 32'd1);
    check("to_reset_cycles", 32'(rn), 32'd2);
    check("to_run_cycles", 32'(en), 32'd16);
    check("to_cycles", cycles_t, 32'd16);
    check("to_verdict", {29'd0, pass_t, fail_t, to_t}, 32'b011);
    check("to_result", result_t, 32'd0);
    check("to_busy_done", {30'd0, busy_t, done_t}, 32'b01);

    // Edge in the very last RUN cycle is captured, not timed out
    pulse_start_t(32'd1, 32'h0000_ABCD);
    wait_enable_t("edge_wait_run");
    repeat (15) tick();
    stub_valid = 1'b1;
    tick();
    check("edge_done", 32'(done_t), 32'd1);
    check("edge_verdict", {29'd0, pass_t, fail_t, to_t}, 32'b100);
    check("edge_cycles", cycles_t, 32'd16);
    check("edge_result", result_t, 32'h0000_ABCD);

    // Valid held high through RST is no edge: times out with result cleared
    pulse_start_t(32'd2, 32'h0000_ABCD);
    wait_done(1'b1, 100, "stuck_done");
    check("stuck_verdict", {29'd0, pass_t, fail_t, to_t}, 32'b011);
    check("stuck_result", result_t, 32'd0);
    check("stuck_cycles", cycles_t, 32'd16);
    stub_valid = 1'b0;

    // Abort mid-RUN
    pulse_start_t(32'h55, 32'd1);
    wait_enable_t("abort_wait_run");
    tick(); tick();
    reset = 1'b1;
    #1;
    check("abort_solver_reset", 32'(sr_t), 32'd1);
    check("abort_enable_now", 32'(en_t), 32'd0);
    tick();
    check("abort_flags", {26'd0, busy_t, done_t, pass_t, fail_t, to_t, en_t}, 32'd0);
    check("abort_cycles", cycles_t, 32'd0);
    check("abort_result", result_t, 32'd0);
    check("abort_smax", smax_t, 32'd0);
    reset = 1'b0;
    tick();
    check("abort_idle_solver_reset", 32'(sr_t), 32'd0);

    // Clean run after abort: edge in RUN cycle 3
    pulse_start_t(32'd3, 32'h0000_ABCD);
    wait_enable_t("clean_wait_run");
    tick(); tick();
    stub_valid = 1'b1;
    tick();
    stub_valid = 1'b0;
    check("clean_done", 32'(done_t), 32'd1);
    check("clean_verdict", {29'd0, pass_t, fail_t, to_t}, 32'b100);
    check("clean_cycles", cycles_t, 32'd3);
    check("clean_result", result_t, 32'h0000_ABCD);
    tick(); tick();
    check("clean_hold_cycles", cycles_t, 32'd3);

    // Euler #2 pass, with a stray start pulse during RUN
    max_e = 32'd4000000; exp_e = 32'd4613732; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    check("e_smax", smax_e, 32'd4000000);
    repeat (6) tick();
    max_e = 32'd10; exp_e = 32'd0; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    wait_done(1'b0, 200, "e_pass_done");
    check("e_pass_verdict", {29'd0, pass_e, fail_e, to_e}, 32'b100);
    check("e_pass_result", result_e, 32'd4613732);
    check("e_pass_cycles", cycles_e, 32'd13);
    check("e_pass_smax", smax_e, 32'd4000000);

    // Restart from DONE with a wrong golden value; inputs changed after start
    max_e = 32'd4000000; exp_e = 32'd4613733; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    max_e = 32'd100; exp_e = 32'd4613732;
    check("e_rerun_busy", 32'(busy_e), 32'd1);
    check("e_rerun_cleared", {29'd0, pass_e, fail_e, to_e}, 32'd0);
    wait_done(1'b0, 200, "e_fail_done");
    check("e_fail_verdict", {29'd0, pass_e, fail_e, to_e}, 32'b010);
    check("e_fail_result", result_e, 32'd4613732);
    check("e_fail_cycles", cycles_e, 32'd13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/euler_runner.md
EULER_RUNNER -- requirements
Module: euler_runner

Interface
REQ-001 SHALL have parameter WIDTH, 32, data width of the bound, the expected value and the result.
REQ-002 SHALL have parameter RESET_CYCLES, 2, number of cycles solver_reset is held high per run (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 50000, maximum RUN cycles before timeout (legal range 1..2^32-1).
REQ-004 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a run.
REQ-007 SHALL have port max_value, input, WIDTH, bound forwarded to the solver; sampled when a start is accepted.
REQ-008 SHALL have port expected, input, WIDTH, golden answer; sampled when a start is accepted.
REQ-009 SHALL have port solver_reset, output, 1, drives the solver's reset.
REQ-010 SHALL have port solver_enable, output, 1, drives the solver's enable.
REQ-011 SHALL have port solver_max_value, output, WIDTH, latched bound driven to the solver.
REQ-012 SHALL have port solver_results_valid, input, 1, solver completion flag (level).
REQ-013 SHALL have port solver_results, input, WIDTH, solver answer.
REQ-014 SHALL have port busy, output, 1, high in the RST and RUN states.
REQ-015 SHALL have port done, output, 1, high in the DONE state.
REQ-016 SHALL have ports pass, fail and timed_out, output, 1 each, run verdict (meaningful while done=1).
REQ-017 SHALL have port result, output, WIDTH, captured solver answer.
REQ-018 SHALL have port cycles, output, 32, number of RUN cycles up to and including the capture or timeout cycle.

Function
REQ-019 SHALL implement an FSM with states IDLE, RST, RUN and DONE.
REQ-020 SHALL go from IDLE or DONE to RST on start=1, and in that cycle latch max_value and expected, clear pass, fail, timed_out, result and cycles, and load the reset counter.
REQ-021 SHALL ignore start while in RST or RUN.
REQ-022 SHALL hold solver_reset=1 and solver_enable=0 for exactly RESET_CYCLES cycles in RST, then move to RUN.
REQ-023 SHALL drive solver_enable=1 and solver_reset=0 in RUN only; solver_enable SHALL be 0 in all other states.
REQ-024 SHALL register solver_results_valid into valid_q every cycle, forcing valid_q to 0 while in RST.
REQ-025 SHALL treat a rising edge (solver_results_valid=1 and valid_q=0) during RUN as completion: capture solver_results into result, set pass or fail from the comparison result==expected, and move to DONE on the next edge.
REQ-026 SHALL ignore a solver_results_valid level held high across RST (no edge means no capture).
REQ-027 SHALL increment cycles once per RUN cycle, saturating at 2^32-1.
REQ-028 SHALL, when a RUN cycle with count value TIMEOUT_CYCLES-1 has no rising edge, set timed_out=1 and fail=1, leave result unchanged, and move to DONE.
REQ-029 SHALL give capture priority over timeout when a rising edge and the timeout occur in the same cycle.
REQ-030 SHALL hold result, cycles and the verdict stable in DONE until the next accepted start.
REQ-031 SHALL keep pass and fail mutually exclusive; timed_out=1 implies fail=1.

Reset
REQ-032 SHALL, on reset=1, enter IDLE and clear busy, done, pass, fail, timed_out, result, cycles, solver_enable, solver_max_value and valid_q, and drive solver_reset=1 for that cycle.
REQ-033 SHALL take priority for reset over start and all other events; a reset during RUN SHALL abort the run with no verdict.
REQ-034 SHALL drive solver_reset=0 in IDLE after reset is released.

Verification
REQ-035 SHALL cover the pass case: euler2 attached, max_value=4000000, expected=4613732, start -> done=1, pass=1, result=4613732, timed_out=0.
REQ-036 SHALL cover the mismatch case: same stimulus with expected=4613733 -> done=1, fail=1, pass=0, result=4613732.
REQ-037 SHALL cover the timeout case: stub solver with valid tied 0, TIMEOUT_CYCLES=16 -> done=1 after 16 RUN cycles, timed_out=1, fail=1, cycles=16, result=0.
REQ-038 SHALL cover the stuck-valid case: stub solver with valid tied 1 through RST -> no capture, timeout verdict.
REQ-039 SHALL cover the abort case: reset asserted mid-RUN -> IDLE next cycle, all outputs 0, and a later start runs cleanly.
REQ-040 SHALL cover restart and ignored start: a second start in DONE reruns with fresh latching, and a start pulse during RUN has no effect on result or cycles.
